// File: rtl/seg7_reader_if.sv
// Multiplexed seven-segment display bus plus recovered-digit readback signals.
// master drives the display lines; slave (the reader) returns the decoded digits.
interface seg7_reader_if #(
   parameter int unsigned DIGITS = 4
);
   logic [DIGITS-1:0]   an_in;
   logic [6:0]          seg_in;
   logic [4*DIGITS-1:0] digit_out;
   logic [DIGITS-1:0]   digit_valid;
   logic [DIGITS-1:0]   digit_blank;
   logic                update;
   logic [2:0]          update_pos;
   logic                err;

   modport master (
      output an_in, seg_in,
      input  digit_out, digit_valid, digit_blank, update, update_pos, err
   );

   modport slave (
      input  an_in, seg_in,
      output digit_out, digit_valid, digit_blank, update, update_pos, err
   );
endinterface

// File: rtl/seg7_reader.sv
// Recovers digits from an active-low multiplexed seven-segment bus.
// Define SEG7_READER_HEX_EN to also decode A-F as numeric values 10-15.
module seg7_reader #(
   parameter int unsigned DIGITS        = 4,
   parameter int unsigned STABLE_CYCLES = 4
) (
   input logic          clk,
   input logic          rst,
   seg7_reader_if.slave bus
);
   typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_e;

   state_e              state_q, state_d;
   logic [DIGITS-1:0]   an_q;
   logic [6:0]          seg_q;
   logic [7:0]          cnt_q, cnt_d, cnt_inc;
   logic [4*DIGITS-1:0] digit_q, digit_d;
   logic [DIGITS-1:0]   valid_q, valid_d, blank_q, blank_d;
   logic                upd_q, upd_d, err_q, err_d;
   logic [2:0]          pos_q, pos_d, sel_pos;
   logic [3:0]          zeros, dec_val;
   logic                legal_new, changed, commit, dec_num, dec_blank;

   // The incoming bus value is compared against the sample register as it is
   // captured, so the counter reaches STABLE_CYCLES on the last capture edge.
   always_comb begin
      zeros = '0;
      for (int unsigned i = 0; i < DIGITS; i++)
         if (!bus.an_in[i]) zeros = zeros + 4'd1;
      legal_new = (zeros == 4'd1);
      changed   = ({bus.an_in, bus.seg_in} != {an_q, seg_q});
      cnt_inc   = (cnt_q == 8'd255) ? cnt_q : cnt_q + 8'd1;
      sel_pos   = '0;
      for (int unsigned i = 0; i < DIGITS; i++)
         if (!an_q[i]) sel_pos = i[2:0];
   end

   always_comb begin
      dec_num   = 1'b1;
      dec_blank = 1'b0;
      dec_val   = '0;
      case (seg_q)
         7'b0000001: dec_val = 4'd0;
         7'b1001111: dec_val = 4'd1;
         7'b0010010: dec_val = 4'd2;
         7'b0000110: dec_val = 4'd3;
         7'b1001100: dec_val = 4'd4;
         7'b0100100: dec_val = 4'd5;
         7'b0100000: dec_val = 4'd6;
         7'b0001111: dec_val = 4'd7;
         7'b0000000: dec_val = 4'd8;
         7'b0000100: dec_val = 4'd9;
`ifdef SEG7_READER_HEX_EN
         7'b0001000: dec_val = 4'hA;
         7'b1100000: dec_val = 4'hB;
         7'b0110001: dec_val = 4'hC;
         7'b1000010: dec_val = 4'hD;
         7'b0110000: dec_val = 4'hE;
         7'b0111000: dec_val = 4'hF;
`endif
         7'b1111111: begin
            dec_num   = 1'b0;
            dec_blank = 1'b1;
         end
         default:    dec_num = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      commit  = 1'b0;
      digit_d = digit_q;
      valid_d = valid_q;
      blank_d = blank_q;
      upd_d   = 1'b0;
      pos_d   = pos_q;
      err_d   = err_q;

      if (state_q == TRACK && cnt_q == 8'(STABLE_CYCLES)) commit = 1'b1;

      if (!legal_new) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else if (state_q == IDLE || changed) begin
         state_d = TRACK;
         cnt_d   = 8'd1;
      end else begin
         state_d = commit ? HOLD : state_q;
         cnt_d   = cnt_inc;
      end

      if (commit) begin
         if (dec_num || dec_blank) begin
            upd_d = 1'b1;
            pos_d = sel_pos;
            for (int unsigned i = 0; i < DIGITS; i++) begin
               if (i[2:0] == sel_pos) begin
                  if (dec_num) digit_d[4*i +: 4] = dec_val;
                  valid_d[i] = dec_num;
                  blank_d[i] = dec_blank;
               end
            end
         end else begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         an_q    <= '1;
         seg_q   <= '1;
         cnt_q   <= '0;
         digit_q <= '0;
         valid_q <= '0;
         blank_q <= '0;
         upd_q   <= 1'b0;
         pos_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         an_q    <= bus.an_in;
         seg_q   <= bus.seg_in;
         cnt_q   <= cnt_d;
         digit_q <= digit_d;
         valid_q <= valid_d;
         blank_q <= blank_d;
         upd_q   <= upd_d;
         pos_q   <= pos_d;
         err_q   <= err_d;
      end
   end

   assign bus.digit_out   = digit_q;
   assign bus.digit_valid = valid_q;
   assign bus.digit_blank = blank_q;
   assign bus.update      = upd_q;
   assign bus.update_pos  = pos_q;
   assign bus.err         = err_q;
endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader: expected commits are queued when driven and
// checked against each update pulse; other outputs checked at fixed points.
module tb_seg7_reader;
   typedef struct {
      logic [2:0] pos;
      logic [3:0] val;
      logic       blank;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int unsigned n_asserts = 0;
   int unsigned n_fail    = 0;
   ev_t sb[$];

   seg7_reader_if #(.DIGITS(4)) dif ();

   seg7_reader #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (dif.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] an, input logic [6:0] seg);
      dif.an_in  = an;
      dif.seg_in = seg;
   endtask

   task automatic expect_ev(input logic [2:0] pos, input logic [3:0] val, input logic blank);
      ev_t e;
      e.pos   = pos;
      e.val   = val;
      e.blank = blank;
      sb.push_back(e);
   endtask

   // Scoreboard side: every update pulse must match the oldest queued commit.
   always @(negedge clk) begin
      if (!rst && dif.update === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_update", {29'd0, dif.update_pos}, 32'hFFFF_FFFF);
         end else begin
            ev_t e;
            e = sb.pop_front();
            chk("update_pos", {29'd0, dif.update_pos}, {29'd0, e.pos});
            if (e.blank) begin
               chk("blank_bit", {31'd0, dif.digit_blank[e.pos]}, 32'd1);
               chk("blank_valid_bit", {31'd0, dif.digit_valid[e.pos]}, 32'd0);
            end else begin
               chk("digit_val", {28'd0, dif.digit_out[4*e.pos +: 4]}, {28'd0, e.val});
               chk("valid_bit", {31'd0, dif.digit_valid[e.pos]}, 32'd1);
            end
         end
      end
   end

   initial begin
      logic [15:0] snap_digits;
      logic [3:0]  snap_valid;
      drive(4'b1111, 7'b1111111);
      cyc(2);
      rst = 1'b0;
      chk("rst_digit_out", {16'd0, dif.digit_out}, 32'd0);
      chk("rst_valid", {28'd0, dif.digit_valid}, 32'd0);
      chk("rst_blank", {28'd0, dif.digit_blank}, 32'd0);
      chk("rst_update", {31'd0, dif.update}, 32'd0);
      chk("rst_err", {31'd0, dif.err}, 32'd0);

      // Digit 2 on position 0: commit exactly at the fifth edge.
      drive(4'b1110, 7'b0010010);
      expect_ev(3'd0, 4'd2, 1'b0);
      cyc(4);
      chk("lat_no_early", {28'd0, dif.digit_valid}, 32'd0);
      cyc(1);
      chk("lat_update", {31'd0, dif.update}, 32'd1);
      chk("lat_digit", {16'd0, dif.digit_out}, 32'h0002);
      chk("lat_valid", {28'd0, dif.digit_valid}, 32'h1);
      cyc(3);
      chk("hold_no_repulse", {31'd0, dif.update}, 32'd0);

      // Short-lived 9 on position 2 must not commit; the following 8 does.
      drive(4'b1011, 7'b0000100);
      cyc(3);
      drive(4'b1011, 7'b0000000);
      expect_ev(3'd2, 4'd8, 1'b0);
      cyc(6);
      chk("glitch_digits", {16'd0, dif.digit_out}, 32'h0802);
      chk("glitch_valid", {28'd0, dif.digit_valid}, 32'h5);

      // Sweep positions with 1,3,5,7.
      drive(4'b1110, 7'b1001111); expect_ev(3'd0, 4'd1, 1'b0); cyc(6);
      drive(4'b1101, 7'b0000110); expect_ev(3'd1, 4'd3, 1'b0); cyc(6);
      drive(4'b1011, 7'b0100100); expect_ev(3'd2, 4'd5, 1'b0); cyc(6);
      drive(4'b0111, 7'b0001111); expect_ev(3'd3, 4'd7, 1'b0); cyc(6);
      chk("sweep_digits", {16'd0, dif.digit_out}, 32'h7531);
      chk("sweep_valid", {28'd0, dif.digit_valid}, 32'hF);

      // Blank position 1.
      drive(4'b1101, 7'b1111111); expect_ev(3'd1, 4'd0, 1'b1); cyc(6);
      chk("blank_mask", {28'd0, dif.digit_blank}, 32'h2);
      chk("blank_valid", {28'd0, dif.digit_valid}, 32'hD);
      chk("blank_digits", {16'd0, dif.digit_out}, 32'h7531);

      // Hex 'A' pattern on position 0.
      drive(4'b1110, 7'b0001000);
`ifdef SEG7_READER_HEX_EN
      expect_ev(3'd0, 4'hA, 1'b0);
      cyc(6);
      chk("hex_digits", {16'd0, dif.digit_out}, 32'h753A);
      chk("hex_err", {31'd0, dif.err}, 32'd0);
`else
      cyc(6);
      chk("hex_digits", {16'd0, dif.digit_out}, 32'h7531);
      chk("hex_err", {31'd0, dif.err}, 32'd1);
`endif

      // Change on the commit edge: old value commits, new one restarts.
      drive(4'b0111, 7'b0100000);
      expect_ev(3'd3, 4'd6, 1'b0);
      expect_ev(3'd3, 4'd3, 1'b0);
      cyc(4);
      drive(4'b0111, 7'b0000110);
      cyc(1);
      chk("edge_commit_old", {31'd0, dif.update}, 32'd1);
      chk("edge_old_digit", {28'd0, dif.digit_out[15:12]}, 32'd6);
      cyc(4);
      chk("edge_commit_new", {31'd0, dif.update}, 32'd1);
      chk("edge_new_digit", {28'd0, dif.digit_out[15:12]}, 32'd3);
      cyc(2);

      // Two digits selected at once: no tracking, nothing changes.
      snap_digits = dif.digit_out;
      snap_valid  = dif.digit_valid;
      drive(4'b1100, 7'b0000000);
      cyc(10);
      chk("illegal_digits", {16'd0, dif.digit_out}, {16'd0, snap_digits});
      chk("illegal_valid", {28'd0, dif.digit_valid}, {28'd0, snap_valid});

      // Reset landing on what would be the commit edge.
      drive(4'b1110, 7'b0000000);
      cyc(4);
      rst = 1'b1;
      drive(4'b1111, 7'b1111111);
      cyc(1);
      rst = 1'b0;
      chk("rstmid_digits", {16'd0, dif.digit_out}, 32'd0);
      chk("rstmid_valid", {28'd0, dif.digit_valid}, 32'd0);
      chk("rstmid_blank", {28'd0, dif.digit_blank}, 32'd0);
      chk("rstmid_update", {31'd0, dif.update}, 32'd0);
      chk("rstmid_pos", {29'd0, dif.update_pos}, 32'd0);
      chk("rstmid_err", {31'd0, dif.err}, 32'd0);
      cyc(4);
      chk("rstmid_after", {31'd0, dif.update}, 32'd0);

      chk("sb_empty", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end
endmodule

// File: doc/seg7_reader.md
# seg7_reader

- Recovers digit values from a time-multiplexed, active-low seven-segment display bus (anode selects plus shared segment lines).
- Exact inverse of the team's BCD-to-seven-segment decoder; same segment encoding.
- Sits in the Password design as a readback monitor on the display outputs, giving self-check logic and benches the digits actually shown.

## Interface
Parameters:
- DIGITS, 4, number of multiplexed digit positions (1-8).
- STABLE_CYCLES, 4, consecutive identical samples required before a pattern is committed (1-255).

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- an_in  input  DIGITS  active-low digit selects; a position is driven when exactly one bit is 0.
- seg_in  input  7  active-low segments; bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
- digit_out  output  4*DIGITS  recovered value per position; position i at bits [4i+3:4i].
- digit_valid  output  DIGITS  position holds a committed numeric value.
- digit_blank  output  DIGITS  last committed pattern at position was all-off (7'b1111111).
- update  output  1  one-cycle pulse on every numeric or blank commit.
- update_pos  output  3  index of the position committed; meaningful only while update=1.
- err  output  1  sticky; set by any committed unrecognised pattern; cleared only by rst.

## Operation
- Input stage: an_in/seg_in registered every cycle into a sample register; previous sample kept for comparison.
- Selection is legal only when exactly one an_in bit is 0. All-ones, or more than one 0, means no selection.
- Stability counter:
  - Resets to 1 when the new sample differs from the previous sample in any bit.
  - Otherwise increments, saturating at 255.
- States:
  - IDLE: no legal selection; counter held at 0; no commits. Legal selection -> TRACK.
  - TRACK: counter running. Illegal selection -> IDLE. Counter reaches STABLE_CYCLES -> commit, then HOLD.
  - HOLD: the same sample persists; no re-commit. Any sample change -> TRACK (counter=1), or IDLE if the new selection is illegal.
- Commit decode:
  - 0-9: patterns 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100.
  - Numeric: write digit_out[pos]; set digit_valid[pos]; clear digit_blank[pos]; pulse update.
  - Blank (1111111): set digit_blank[pos]; clear digit_valid[pos]; digit_out[pos] unchanged; pulse update.
  - Any other pattern: set err; no update pulse; all per-position outputs unchanged.
- Positions are independent. A commit to one position never alters another.

## Timing
- Reset values: digit_out=0; digit_valid=0; digit_blank=0; update=0; update_pos=0; err=0; state IDLE; counter 0; sample registers all ones.
- Latency: inputs applied before edge 1 and held are captured at edges 1..STABLE_CYCLES. Outputs change at edge STABLE_CYCLES+1 (default: 5 cycles).
- update is high for exactly one cycle per commit; update_pos is valid in that same cycle.
- Input change on the commit edge: the commit uses the previously stable sample; the new sample restarts the counter at 1.
- An input glitch shorter than STABLE_CYCLES never commits.
- With STABLE_CYCLES=1, every changed legal sample commits on the following edge.
- rst asserted mid-track or in HOLD: all state and outputs return to reset values on that edge. No partial commit.

## Configuration
- SEG7_READER_HEX_EN defined: additionally decodes 10-15 as numeric.
  - Patterns: 0001000=A, 1100000=b, 0110001=C, 1000010=d, 0110000=E, 0111000=F.
- SEG7_READER_HEX_EN undefined: those six patterns are unrecognised and set err.

## Test plan
- Defaults; an_in=4'b1110, seg_in=7'b0010010 held for 8 cycles -> at edge 5: digit_out[3:0]=2, digit_valid=4'b0001, update pulses once with update_pos=0; no further pulse.
- an_in=4'b1011, seg_in=7'b0000100 held 3 cycles, then seg_in changed -> no commit. Then new value held 4 more captures -> commit to position 2 only.
- Cycle positions 0-3 with patterns 1,3,5,7 held 6 cycles each -> digit_out=16'h7531, digit_valid=4'b1111; four update pulses.
- After the previous scenario, position 1 shows 1111111 -> digit_blank=4'b0010, digit_valid=4'b1101, digit_out unchanged.
- Pattern 7'b0001000 stable on position 0 -> without macro: err=1, no update. With SEG7_READER_HEX_EN: digit_out[3:0]=4'hA, update pulses, err stays 0.
- an_in=4'b1100 held 10 cycles -> stays IDLE, no outputs change. rst pulsed on the commit edge of a legal pattern -> all outputs at reset values, no update.
